// File: rtl/ccm_block_pack_if.sv
// ccm_block_pack_if -- byte-in / block-out stream bundle for ccm_block_pack.
//   input_data/input_en/input_last : plaintext byte stream towards the packer
//   in_ready                       : packer accepts a byte when input_en && in_ready
//   out_block/out_valid/out_last   : 128-bit packed block, first byte in [127:120]
//   out_byte_cnt/out_block_idx     : valid bytes (1..16) and CTR index of the block
//   out_ready                      : downstream accepts when out_valid && out_ready
// master = byte source / block sink side, slave = the packer.
interface ccm_block_pack_if #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned WIDTH_COUNT = 20
);
  logic [WIDTH-1:0]       input_data;
  logic                   input_en;
  logic                   input_last;
  logic                   in_ready;
  logic [127:0]           out_block;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [4:0]             out_byte_cnt;
  logic [WIDTH_COUNT-1:0] out_block_idx;

  modport master (
    output input_data, input_en, input_last, out_ready,
    input  in_ready, out_block, out_valid, out_last, out_byte_cnt, out_block_idx
  );

  modport slave (
    input  input_data, input_en, input_last, out_ready,
    output in_ready, out_block, out_valid, out_last, out_byte_cnt, out_block_idx
  );
endinterface

// File: rtl/ccm_block_pack.sv
// ccm_block_pack -- packs a CCM plaintext byte stream into 128-bit blocks for
// the CTR/AES stage, tagging each block with its byte count, last flag and CTR
// block index (starting at 1; index 0 is reserved for the MIC).
// Ports:
//   clk      : single clock, rising edge
//   reset    : asynchronous, active-low
//   bus      : ccm_block_pack_if.slave (byte input stream and block output stream)
//   ovf_err  : sticky, a byte was offered while in_ready was low
//   msg_len  : (only with CCM_PACK_MSG_LEN_EN) accepted byte count of the message,
//              valid while out_valid && out_last, saturating at 65535
// Optional feature macro: CCM_PACK_MSG_LEN_EN.
module ccm_block_pack #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned WIDTH_COUNT = 20
) (
  input  logic                clk,
  input  logic                reset,
  ccm_block_pack_if.slave     bus,
  output logic                ovf_err
`ifdef CCM_PACK_MSG_LEN_EN
  ,
  output logic [15:0]         msg_len
`endif
);

  localparam int unsigned          BYTES   = 128 / WIDTH;
  localparam logic [0:0]           FILL    = 1'b0;
  localparam logic [0:0]           HOLD    = 1'b1;
  localparam logic [WIDTH_COUNT-1:0] IDX_ONE = WIDTH_COUNT'(1);

  logic [0:0]             state;
  logic                   run;
  logic [3:0]             ptr;
  logic [127:0]           acc;
  logic [127:0]           acc_w;

  // Closed block waiting one cycle before entering the output register.
  logic                   pend_v;
  logic [127:0]           pend_blk;
  logic [4:0]             pend_cnt;
  logic                   pend_last;
  logic [WIDTH_COUNT-1:0] nxt_idx;

  logic [127:0]           ob;
  logic                   ov;
  logic                   ol;
  logic [4:0]             oc;
  logic [WIDTH_COUNT-1:0] oi;

  logic                   in_ready_w;
  logic                   accept;
  logic                   close;
  logic                   load;
  logic                   ov_next;

  assign in_ready_w = run && (state == FILL);
  assign accept     = bus.input_en && in_ready_w;
  // A lone input_last only closes a block that already holds bytes.
  assign close      = in_ready_w &&
                      ((bus.input_en && ((ptr == 4'd15) || bus.input_last)) ||
                       (!bus.input_en && bus.input_last && (ptr != 4'd0)));
  assign load       = pend_v && (!ov || bus.out_ready);
  assign ov_next    = load || (ov && !bus.out_ready);

  assign bus.in_ready      = in_ready_w;
  assign bus.out_block     = ob;
  assign bus.out_valid     = ov;
  assign bus.out_last      = ol;
  assign bus.out_byte_cnt  = oc;
  assign bus.out_block_idx = oi;

  always_comb begin
    acc_w = acc;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (accept && (ptr == 4'(k))) begin
        acc_w[127 - WIDTH*k -: WIDTH] = bus.input_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      run       <= 1'b0;
      ptr       <= '0;
      acc       <= '0;
      pend_v    <= 1'b0;
      pend_blk  <= '0;
      pend_cnt  <= '0;
      pend_last <= 1'b0;
      nxt_idx   <= IDX_ONE;
      ob        <= '0;
      ov        <= 1'b0;
      ol        <= 1'b0;
      oc        <= '0;
      oi        <= IDX_ONE;
      ovf_err   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (bus.input_en && !in_ready_w) begin
        ovf_err <= 1'b1;
      end

      if (close) begin
        acc       <= '0;
        ptr       <= '0;
        pend_v    <= 1'b1;
        pend_blk  <= acc_w;
        pend_cnt  <= {1'b0, ptr} + {4'b0, accept};
        pend_last <= bus.input_last;
      end else begin
        acc <= acc_w;
        if (accept) begin
          ptr <= ptr + 4'd1;
        end
        if (load) begin
          pend_v <= 1'b0;
        end
      end

      if (load) begin
        ob      <= pend_blk;
        oc      <= pend_cnt;
        ol      <= pend_last;
        oi      <= nxt_idx;
        nxt_idx <= pend_last ? IDX_ONE : nxt_idx + IDX_ONE;
      end
      ov <= ov_next;

      // A block closing into an occupied output register must wait in HOLD;
      // otherwise it moves out next cycle and input keeps streaming.
      if (close && ov_next) begin
        state <= HOLD;
      end else if (load) begin
        state <= FILL;
      end
    end
  end

`ifdef CCM_PACK_MSG_LEN_EN
  logic [15:0] len_cnt;
  logic [15:0] len_cnt_w;
  logic [15:0] pend_len;
  logic [15:0] len_r;

  always_comb begin
    len_cnt_w = len_cnt;
    if (accept && (len_cnt != 16'hFFFF)) begin
      len_cnt_w = len_cnt + 16'd1;
    end
  end

  // The running count is snapshotted per message so the next message can
  // stream in while the previous last block is still presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_cnt  <= '0;
      pend_len <= '0;
      len_r    <= '0;
    end else begin
      if (close && bus.input_last) begin
        len_cnt  <= '0;
        pend_len <= len_cnt_w;
      end else begin
        len_cnt <= len_cnt_w;
      end
      if (load) begin
        len_r <= pend_last ? pend_len : '0;
      end else if (ov && bus.out_ready && ol) begin
        len_r <= '0;
      end
    end
  end

  assign msg_len = len_r;
`endif

endmodule

// File: tb/tb_ccm_block_pack.sv
// tb_ccm_block_pack -- directed self-checking bench for ccm_block_pack.
// Blocks handed downstream are captured on the falling edge and compared with
// hand-computed constants.
module tb_ccm_block_pack;

  logic clk;
  logic reset;
  logic ovf_err;
`ifdef CCM_PACK_MSG_LEN_EN
  logic [15:0] msg_len;
`endif

  int asserts = 0;
  int fails   = 0;

  ccm_block_pack_if #(.WIDTH(8), .WIDTH_COUNT(20)) bus ();

  ccm_block_pack #(.WIDTH(8), .WIDTH_COUNT(20)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ovf_err (ovf_err)
`ifdef CCM_PACK_MSG_LEN_EN
    ,
    .msg_len (msg_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] blk_q [$];
  logic [4:0]   cnt_q [$];
  logic         last_q[$];
  logic [19:0]  idx_q [$];
  logic [15:0]  len_q [$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      blk_q.push_back(bus.out_block);
      cnt_q.push_back(bus.out_byte_cnt);
      last_q.push_back(bus.out_last);
      idx_q.push_back(bus.out_block_idx);
`ifdef CCM_PACK_MSG_LEN_EN
      len_q.push_back(msg_len);
`else
      len_q.push_back(16'd0);
`endif
    end
  end

  task automatic clear_q();
    blk_q.delete(); cnt_q.delete(); last_q.delete(); idx_q.delete(); len_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bus.input_en   = 1'b1;
    bus.input_data = d;
    bus.input_last = last;
    @(posedge clk); #1;
    bus.input_en   = 1'b0;
    bus.input_last = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    for (int c = 0; c < 60 && blk_q.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.input_en = 1'b0; bus.input_last = 1'b0; bus.input_data = '0; bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    #2;
    asserts++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
    asserts++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL rst_last got %b exp 0", bus.out_last); end
    asserts++; if (bus.out_block !== 128'h0) begin fails++; $display("FAIL rst_block got %h exp 0", bus.out_block); end
    asserts++; if (bus.out_byte_cnt !== 5'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", bus.out_byte_cnt); end
    asserts++; if (bus.out_block_idx !== 20'd1) begin fails++; $display("FAIL rst_idx got %0d exp 1", bus.out_block_idx); end
    asserts++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    asserts++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b exp 0", ovf_err); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    asserts++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rel_in_ready_pre got %b exp 0", bus.in_ready); end
    @(posedge clk); #1;
    asserts++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready_post got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_two_full();
    int ir_low = 0;
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (bus.in_ready !== 1'b1) ir_low++;
      send_byte(8'(i), i == 31);
      if (i == 15) begin
        asserts++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL lat_early got %b exp 0", bus.out_valid); end
      end
      if (i == 16) begin
        asserts++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL lat_valid got %b exp 1", bus.out_valid); end
        asserts++; if (bus.out_block !== 128'h000102030405060708090a0b0c0d0e0f) begin fails++; $display("FAIL lat_block got %h", bus.out_block); end
      end
    end
    wait_blocks(2);
    asserts++; if (ir_low != 0) begin fails++; $display("FAIL full_in_ready_low got %0d exp 0", ir_low); end
    asserts++; if (blk_q.size() != 2) begin fails++; $display("FAIL full_nblk got %0d exp 2", blk_q.size()); end
    asserts++; if (blk_q[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin fails++; $display("FAIL full_blk0 got %h", blk_q[0]); end
    asserts++; if (idx_q[0] !== 20'd1 || cnt_q[0] !== 5'd16 || last_q[0] !== 1'b0) begin fails++; $display("FAIL full_meta0 got idx %0d cnt %0d last %b exp 1 16 0", idx_q[0], cnt_q[0], last_q[0]); end
    asserts++; if (blk_q[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin fails++; $display("FAIL full_blk1 got %h", blk_q[1]); end
    asserts++; if (idx_q[1] !== 20'd2 || cnt_q[1] !== 5'd16 || last_q[1] !== 1'b1) begin fails++; $display("FAIL full_meta1 got idx %0d cnt %0d last %b exp 2 16 1", idx_q[1], cnt_q[1], last_q[1]); end
  endtask

  task automatic test_partial();
    clear_q();
    bus.out_ready = 1'b1;
    bus.input_last = 1'b1;
    @(posedge clk); #1;
    bus.input_last = 1'b0;
    for (int i = 0; i < 29; i++) send_byte(8'(8'h40 + i), 1'b0);
    bus.input_last = 1'b1;
    @(posedge clk); #1;
    bus.input_last = 1'b0;
    wait_blocks(2);
    asserts++; if (blk_q.size() != 2) begin fails++; $display("FAIL part_nblk got %0d exp 2", blk_q.size()); end
    asserts++; if (blk_q[0] !== 128'h404142434445464748494a4b4c4d4e4f) begin fails++; $display("FAIL part_blk0 got %h", blk_q[0]); end
    asserts++; if (blk_q[1] !== 128'h505152535455565758595a5b5c000000) begin fails++; $display("FAIL part_blk1 got %h", blk_q[1]); end
    asserts++; if (idx_q[1] !== 20'd2 || cnt_q[1] !== 5'd13 || last_q[1] !== 1'b1) begin fails++; $display("FAIL part_meta1 got idx %0d cnt %0d last %b exp 2 13 1", idx_q[1], cnt_q[1], last_q[1]); end
`ifdef CCM_PACK_MSG_LEN_EN
    asserts++; if (len_q[1] !== 16'd29) begin fails++; $display("FAIL part_msg_len got %0d exp 29", len_q[1]); end
`endif
  endtask

  task automatic test_backpressure();
    int first_low = -1;
    clear_q();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready !== 1'b1 && first_low < 0) first_low = i;
      send_byte(8'(8'h80 + i), 1'b0);
    end
    asserts++; if (first_low != 32) begin fails++; $display("FAIL bp_first_stall got %0d exp 32", first_low); end
    asserts++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL bp_ovf got %b exp 1", ovf_err); end
    repeat (3) @(posedge clk);
    #1;
    asserts++; if (bus.out_valid !== 1'b1 || bus.out_block !== 128'h808182838485868788898a8b8c8d8e8f) begin fails++; $display("FAIL bp_hold_block got v %b %h", bus.out_valid, bus.out_block); end
    asserts++; if (bus.out_block_idx !== 20'd1 || bus.out_byte_cnt !== 5'd16 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_meta got idx %0d cnt %0d rdy %b exp 1 16 0", bus.out_block_idx, bus.out_byte_cnt, bus.in_ready); end
    bus.out_ready = 1'b1;
    wait_blocks(2);
    asserts++; if (blk_q.size() != 2) begin fails++; $display("FAIL bp_nblk got %0d exp 2", blk_q.size()); end
    asserts++; if (blk_q[0] !== 128'h808182838485868788898a8b8c8d8e8f || idx_q[0] !== 20'd1) begin fails++; $display("FAIL bp_blk0 got idx %0d %h", idx_q[0], blk_q[0]); end
    asserts++; if (blk_q[1] !== 128'h909192939495969798999a9b9c9d9e9f || idx_q[1] !== 20'd2) begin fails++; $display("FAIL bp_blk1 got idx %0d %h", idx_q[1], blk_q[1]); end
    asserts++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky got %b exp 1", ovf_err); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'h11, 1'b0);
    #2 reset = 1'b0;
    #1;
    asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || ovf_err !== 1'b0) begin fails++; $display("FAIL mid_rst_state got v %b rdy %b ovf %b exp 0 0 0", bus.out_valid, bus.in_ready, ovf_err); end
    asserts++; if (bus.out_block_idx !== 20'd1) begin fails++; $display("FAIL mid_rst_idx got %0d exp 1", bus.out_block_idx); end
    @(negedge clk);
    clear_q();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send_byte(8'hAA, i == 15);
    wait_blocks(1);
    asserts++; if (blk_q.size() != 1) begin fails++; $display("FAIL mid_nblk got %0d exp 1", blk_q.size()); end
    asserts++; if (blk_q[0] !== {16{8'hAA}}) begin fails++; $display("FAIL mid_blk got %h", blk_q[0]); end
    asserts++; if (idx_q[0] !== 20'd1 || cnt_q[0] !== 5'd16 || last_q[0] !== 1'b1) begin fails++; $display("FAIL mid_meta got idx %0d cnt %0d last %b exp 1 16 1", idx_q[0], cnt_q[0], last_q[0]); end
  endtask

  task automatic test_back_to_back();
    int ir_low = 0;
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (bus.in_ready !== 1'b1) ir_low++;
      send_byte(8'(i), (i == 5) || (i == 8));
    end
    wait_blocks(2);
    asserts++; if (ir_low != 0) begin fails++; $display("FAIL b2b_in_ready_low got %0d exp 0", ir_low); end
    asserts++; if (blk_q.size() != 2) begin fails++; $display("FAIL b2b_nblk got %0d exp 2", blk_q.size()); end
    asserts++; if (blk_q[0] !== 128'h01020304050000000000000000000000) begin fails++; $display("FAIL b2b_blk0 got %h", blk_q[0]); end
    asserts++; if (idx_q[0] !== 20'd1 || cnt_q[0] !== 5'd5 || last_q[0] !== 1'b1) begin fails++; $display("FAIL b2b_meta0 got idx %0d cnt %0d last %b exp 1 5 1", idx_q[0], cnt_q[0], last_q[0]); end
    asserts++; if (blk_q[1] !== 128'h06070800000000000000000000000000) begin fails++; $display("FAIL b2b_blk1 got %h", blk_q[1]); end
    asserts++; if (idx_q[1] !== 20'd1 || cnt_q[1] !== 5'd3 || last_q[1] !== 1'b1) begin fails++; $display("FAIL b2b_meta1 got idx %0d cnt %0d last %b exp 1 3 1", idx_q[1], cnt_q[1], last_q[1]); end
`ifdef CCM_PACK_MSG_LEN_EN
    asserts++; if (len_q[0] !== 16'd5 || len_q[1] !== 16'd3) begin fails++; $display("FAIL b2b_msg_len got %0d %0d exp 5 3", len_q[0], len_q[1]); end
`endif
  endtask

  initial begin
    test_reset();
    test_two_full();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/ccm_block_pack.md
CCM_BLOCK_PACK -- requirements
Module: ccm_block_pack

Interface
REQ-001 Parameter WIDTH, 8, input byte width; SHALL be fixed at 8.
REQ-002 Parameter WIDTH_COUNT, 20, width of CTR block index.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 input_data  input  WIDTH  plaintext byte.
REQ-006 input_en  input  1  byte valid qualifier.
REQ-007 input_last  input  1  end of message; with input_en marks final byte, alone closes partial block.
REQ-008 in_ready  output  1  byte acceptance; byte taken when input_en && in_ready.
REQ-009 out_block  output  128  packed block, first byte in [127:120].
REQ-010 out_valid  output  1  out_block valid.
REQ-011 out_ready  input  1  downstream (ccm_ctr/AES) accepts block when out_valid && out_ready.
REQ-012 out_last  output  1  block is last of message.
REQ-013 out_byte_cnt  output  5  valid bytes in block, 1..16.
REQ-014 out_block_idx  output  WIDTH_COUNT  CTR index of block.
REQ-015 ovf_err  output  1  sticky: byte offered while in_ready low.

Function
REQ-016 Byte k of block SHALL occupy out_block[127-8k -: 8]; unused bytes SHALL be zero.
REQ-017 States FILL (accumulating, ptr 0..15) and HOLD (block closed, output register occupied); reset enters FILL, ptr=0.
REQ-018 Block SHALL close when 16th byte accepted, or accepted byte has input_last, or input_last with input_en=0 and ptr>0.
REQ-019 input_last with input_en=0 and ptr=0 SHALL be ignored.
REQ-020 Closed block SHALL transfer to output register next cycle if out_valid=0 or out_ready=1 that cycle; else FSM SHALL enter HOLD.
REQ-021 Latency: closing byte accepted at edge N -> out_valid=1 after edge N+1 when output register free.
REQ-022 in_ready SHALL be 0 in HOLD, 1 in FILL; HOLD -> FILL on edge where output register is accepted.
REQ-023 Back-to-back full-rate input with out_ready=1 SHALL never deassert in_ready.
REQ-024 out_block, out_last, out_byte_cnt, out_block_idx SHALL stay stable while out_valid && !out_ready.
REQ-025 out_block_idx SHALL start at 1 (index 0 reserved for MIC), increment per accepted block, wrap 2^WIDTH_COUNT-1 -> 0, return to 1 after out_last block accepted.
REQ-026 input_en with in_ready=0 SHALL drop the byte and set ovf_err until reset.
REQ-027 Accumulator SHALL be cleared to zero when a block closes.

Reset
REQ-028 On reset=0: out_valid=0, out_last=0, out_block=0, out_byte_cnt=0, out_block_idx=1, in_ready=0, ovf_err=0, ptr=0, state FILL.
REQ-029 in_ready SHALL go 1 on first clk edge after reset release.
REQ-030 Reset mid-message SHALL discard partial and held blocks; no block emitted for them.

Configuration
REQ-031 Macro CCM_PACK_MSG_LEN_EN defined: output msg_len [15:0] SHALL count accepted message bytes, valid and stable while out_valid && out_last, cleared after out_last block accepted and on reset; saturates at 65535.
REQ-032 Macro undefined: msg_len port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 32 bytes 0x00..0x1F, input_en continuous, last on byte 0x1F, out_ready=1 -> two blocks 0x000102..0F idx1 cnt16, 0x1011..1F idx2 cnt16 last=1; in_ready never 0.
REQ-034 29 bytes (230-bit MATLAB vector rounded up) then input_last alone -> 2 blocks, second cnt13, bytes 13..15 zero, out_last=1.
REQ-035 out_ready=0 while 40 bytes offered -> block1 held, block2 closes, in_ready=0 at byte 33, ovf_err=1 if input_en kept high; release out_ready -> idx1,idx2 in order.
REQ-036 reset pulled low after 7 bytes, released, then 16 bytes 0xAA with last -> single block all 0xAA, idx1, cnt16.
REQ-037 Two messages 5 bytes and 3 bytes back-to-back -> idx1 cnt5 last, then idx1 cnt3 last; with CCM_PACK_MSG_LEN_EN msg_len=5 then 3.
